orientation_sequencer: RTL and testbench
========================================

ORIENTATION_SEQUENCER -- requirements
Module: orientation_sequencer

Interface
REQ-001 Parameter MOVE_CYCLES, default 25000000, cycles move_forward is held high between the two measurements.
REQ-002 Parameter MATH_CYCLES, default 4, cycles allowed for orientation_math to settle after both operands are latched.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000000, maximum cycles spent waiting for one location result.
REQ-004 Parameter MAX_RETRIES, default 2, re-requests allowed per measurement after an invalid result.
REQ-005 Port list:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins an orientation run.
- loc_valid  in  1  one-cycle pulse; loc_r_theta is valid.
- loc_r_theta  in  12  measurement, r [7:0], theta code [11:8].
- math_orientation  in  4  result from the orientation_math instance.
- loc_request  out  1  one-cycle pulse requesting a location measurement.
- move_forward  out  1  level; drive robot straight ahead.
- math_orig  out  12  registered first measurement, to the orientation_math instance.
- math_final  out  12  registered second measurement, to the orientation_math instance.
- orientation  out  4  latched result.
- done  out  1  one-cycle pulse; orientation updated.
- busy  out  1  high in every state except IDLE.
- error  out  1  sticky failure flag.

Function
REQ-006 States SHALL be IDLE, REQ1, WAIT1, MOVE, REQ2, WAIT2, MATH and FINISH, all registered on clock.
REQ-007 IDLE SHALL go to REQ1 on start and SHALL clear error in the same transition.
REQ-008 start SHALL be ignored in every state other than IDLE.
REQ-009 REQ1 and REQ2 SHALL assert loc_request for exactly one cycle, then go to WAIT1 and WAIT2 respectively; the timeout counter SHALL be cleared on entry to a WAIT state.
REQ-010 A result SHALL be valid when loc_valid=1, loc_r_theta[7:0]!=0 and loc_r_theta[11:8] is in 1..6.
REQ-011 In WAIT1, a valid result SHALL be latched into math_orig and SHALL move the FSM to MOVE.
REQ-012 In WAIT2, a valid result SHALL be latched into math_final and SHALL move the FSM to MATH.
REQ-013 In a WAIT state, loc_valid with an invalid result SHALL increment the retry count and return to the matching REQ state.
REQ-014 If the retry count already equals MAX_RETRIES when another invalid result arrives, the FSM SHALL set error and go to IDLE.
REQ-015 The retry count SHALL reset to 0 on entry to REQ1 from IDLE and on entry to MOVE.
REQ-016 A WAIT state lasting TIMEOUT_CYCLES cycles without loc_valid SHALL set error and go to IDLE.
REQ-017 loc_valid SHALL be ignored outside WAIT1 and WAIT2.
REQ-018 MOVE SHALL hold move_forward=1 for exactly MOVE_CYCLES cycles, then go to REQ2.
REQ-019 move_forward SHALL be 0 in every other state.
REQ-020 MATH SHALL last exactly MATH_CYCLES cycles, then go to FINISH.
REQ-021 FINISH SHALL latch math_orientation into orientation, pulse done for one cycle and return to IDLE.
REQ-022 orientation, math_orig and math_final SHALL hold their values until overwritten, including across an error abort.
REQ-023 Latency from the loc_valid that completes WAIT2 to done SHALL be MATH_CYCLES+2 cycles.
REQ-024 Counters SHALL be wide enough for the largest parameter value and SHALL NOT wrap during operation.

Reset
REQ-025 While reset=1 at a clock edge, the FSM SHALL be in IDLE and all counters SHALL be 0.
REQ-026 On the same edge, loc_request, move_forward, done, busy and error SHALL be 0.
REQ-027 On the same edge, orientation, math_orig and math_final SHALL be 0.
REQ-028 Reset asserted mid-run, including during MOVE, SHALL drop move_forward on the next edge, and no done SHALL follow.

Verification (bench overrides MOVE_CYCLES=8, MATH_CYCLES=4, TIMEOUT_CYCLES=20, MAX_RETRIES=2)
REQ-029 Nominal run: start, then valid results 12'h150 and 12'h260 -> math_orig=12'h150, math_final=12'h260, move_forward high for exactly 8 cycles, done 6 cycles after the second loc_valid, orientation equals math_orientation, busy low after done.
REQ-030 Retry: first result 12'h100 (r=0), then 12'h150 -> exactly two loc_request pulses before MOVE, and no error.
REQ-031 Retry exhaustion: three consecutive results with theta=0 in WAIT1 -> error=1, FSM back in IDLE, move_forward never asserted.
REQ-032 Timeout: no loc_valid for 20 cycles in WAIT2 -> error=1, busy=0; a later start clears error.
REQ-033 Stray input: start and loc_valid pulsed during MOVE -> both ignored, MOVE length unchanged.
REQ-034 Reset on the 4th cycle of MOVE -> move_forward=0 and all outputs at reset values on the next edge, with no done pulse.

Source files
------------

// File: rtl/orientation_sequencer.sv
// orientation_sequencer: takes two location fixes with a straight move in between,
// then hands them to orientation_math and latches its result.
module orientation_sequencer #(
    parameter int MOVE_CYCLES    = 25000000,
    parameter int MATH_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        loc_valid,
    input  logic [11:0] loc_r_theta,
    input  logic [3:0]  math_orientation,
    output logic        loc_request,
    output logic        move_forward,
    output logic [11:0] math_orig,
    output logic [11:0] math_final,
    output logic [3:0]  orientation,
    output logic        done,
    output logic        busy,
    output logic        error
);
    localparam int MAX_MT = MOVE_CYCLES > MATH_CYCLES ? MOVE_CYCLES : MATH_CYCLES;
    localparam int MAX_C  = MAX_MT > TIMEOUT_CYCLES ? MAX_MT : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam int RW     = $clog2(MAX_RETRIES + 2);

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, MOVE, REQ2, WAIT2, MATH, FINISH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry, retry_n;
    logic          err_n, good;

    assign good         = loc_valid && loc_r_theta[7:0] != 8'd0 && loc_r_theta[11:8] inside {[4'd1:4'd6]};
    assign loc_request  = state == REQ1 || state == REQ2;
    assign move_forward = state == MOVE;
    assign busy         = state != IDLE;

    always_comb begin
        state_n = state;
        retry_n = retry;
        err_n   = error;
        case (state)
            IDLE: if (start) begin
                state_n = REQ1;
                retry_n = '0;
                err_n   = 1'b0;
            end
            REQ1: state_n = WAIT1;
            REQ2: state_n = WAIT2;
            WAIT1, WAIT2: if (loc_valid) begin
                if (good) begin
                    state_n = state == WAIT1 ? MOVE : MATH;
                    retry_n = state == WAIT1 ? '0 : retry;
                end else if (retry == RW'(MAX_RETRIES)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end else begin
                    state_n = state == WAIT1 ? REQ1 : REQ2;
                    retry_n = retry + 1'b1;
                end
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end
            MOVE:   state_n = cnt == CW'(MOVE_CYCLES - 1) ? REQ2 : MOVE;
            MATH:   state_n = cnt == CW'(MATH_CYCLES - 1) ? FINISH : MATH;
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // cnt restarts on every state change and never runs while idle
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            retry       <= '0;
            error       <= 1'b0;
            done        <= 1'b0;
            orientation <= '0;
            math_orig   <= '0;
            math_final  <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
            retry <= retry_n;
            error <= err_n;
            done  <= state == FINISH;
            if (state == FINISH) orientation <= math_orientation;
            if (state == WAIT1 && good) math_orig <= loc_r_theta;
            if (state == WAIT2 && good) math_final <= loc_r_theta;
        end
    end
endmodule

// File: tb/tb_orientation_sequencer.sv
// tb_orientation_sequencer: randomized runs checked against a transaction-level model
// of the two-measurement orientation procedure.
module tb_orientation_sequencer;
    localparam int MOVE = 8, MATHC = 4, TO = 20, MR = 2;

    logic        clock = 0, reset = 1, start = 0, loc_valid = 0;
    logic [11:0] loc_r_theta = '0;
    logic [3:0]  math_orientation;
    logic        loc_request, move_forward, done, busy, error;
    logic [11:0] math_orig, math_final;
    logic [3:0]  orientation;

    int tests = 0, failed = 0;
    int cyc = 0, req_cnt = 0, mv_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic [11:0] exp_orig = '0, exp_final = '0;
    logic [3:0]  exp_orient = '0;
    logic [11:0] q1[$], q2[$];
    bit stray;

    orientation_sequencer #(.MOVE_CYCLES(MOVE), .MATH_CYCLES(MATHC), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
        .clock(clock), .reset(reset), .start(start), .loc_valid(loc_valid), .loc_r_theta(loc_r_theta),
        .math_orientation(math_orientation), .loc_request(loc_request), .move_forward(move_forward),
        .math_orig(math_orig), .math_final(math_final), .orientation(orientation),
        .done(done), .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    // stand-in for the orientation_math instance
    function automatic logic [3:0] orient_of(input logic [11:0] o, input logic [11:0] f);
        return 4'(o[11:8] + f[11:8] + f[3:0]);
    endfunction
    assign math_orientation = orient_of(math_orig, math_final);

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        req_cnt = req_cnt + int'(loc_request);
        mv_cnt  = mv_cnt + int'(move_forward);
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_valid(input logic [11:0] v);
        return v[7:0] != 0 && v[11:8] >= 1 && v[11:8] <= 6;
    endfunction

    // one measurement: how many requests it takes and whether it yields a fix
    function automatic void meas(input logic [11:0] q[$], output int reqs, output bit ok, output logic [11:0] val);
        int retries = 0;
        reqs = 1;
        ok = 0;
        val = '0;
        foreach (q[i]) begin
            if (is_valid(q[i])) begin
                ok = 1;
                val = q[i];
                return;
            end
            if (retries == MR) return;
            retries++;
            reqs++;
        end
    endfunction

    function automatic logic [11:0] rnd_valid();
        return {4'($urandom_range(1, 6)), 8'($urandom_range(1, 255))};
    endfunction

    function automatic logic [11:0] rnd_bad();
        if ($urandom_range(0, 1) == 1) return {4'($urandom_range(0, 15)), 8'h00};
        return {($urandom_range(0, 1) == 1 ? 4'h0 : 4'($urandom_range(7, 15))), 8'($urandom_range(0, 255))};
    endfunction

    task automatic gen(output logic [11:0] q[$]);
        q = {};
        repeat ($urandom_range(0, 3)) q.push_back(rnd_bad());
        if ($urandom_range(0, 4) != 0) q.push_back(rnd_valid());
    endtask

    task automatic respond(input logic [11:0] q[$], input int n, inout int lv_cyc);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!loc_request && w < 40) begin
                @(negedge clock);
                w++;
            end
            check("req_seen", loc_request, 1);
            if (!loc_request) return;
            @(negedge clock);
            if (i >= q.size()) return;
            repeat ($urandom_range(0, 3)) @(negedge clock);
            loc_valid = 1;
            loc_r_theta = q[i];
            lv_cyc = cyc;
            @(negedge clock);
            loc_valid = 0;
            loc_r_theta = 12'($urandom);
        end
    endtask

    task automatic run_case(input string name);
        int r1, r2, lv = 0, b_req, b_mv, b_done, w = 0;
        bit ok1, ok2;
        logic [11:0] v1, v2;
        meas(q1, r1, ok1, v1);
        if (ok1) meas(q2, r2, ok2, v2);
        else begin
            r2 = 0;
            ok2 = 0;
            v2 = '0;
        end
        b_req = req_cnt;
        b_mv = mv_cnt;
        b_done = done_cnt;
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
        check($sformatf("%s:err_clr", name), error, 0);
        respond(q1, r1, lv);
        if (ok1) begin
            if (stray) begin
                repeat (3) @(negedge clock);
                start = 1;
                loc_valid = 1;
                loc_r_theta = 12'h4CC;
                @(negedge clock);
                start = 0;
                loc_valid = 0;
            end
            respond(q2, r2, lv);
        end
        while (busy && w < 100) begin
            @(negedge clock);
            w++;
        end
        repeat (2) @(negedge clock);
        if (ok1) exp_orig = v1;
        if (ok2) begin
            exp_final = v2;
            exp_orient = orient_of(exp_orig, exp_final);
        end
        check($sformatf("%s:busy", name), busy, 0);
        check($sformatf("%s:reqs", name), req_cnt - b_req, r1 + r2);
        check($sformatf("%s:move", name), mv_cnt - b_mv, ok1 ? MOVE : 0);
        check($sformatf("%s:done_n", name), done_cnt - b_done, ok2 ? 1 : 0);
        check($sformatf("%s:error", name), error, !(ok1 && ok2));
        check($sformatf("%s:orig", name), math_orig, exp_orig);
        check($sformatf("%s:final", name), math_final, exp_final);
        check($sformatf("%s:orient", name), orientation, exp_orient);
        if (ok2) check($sformatf("%s:latency", name), done_cyc - lv, MATHC + 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lv = 0, b_done;
        repeat (3) @(negedge clock);
        check("rst_req", loc_request, 0);
        check("rst_move", move_forward, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_orient", orientation, 0);
        check("rst_orig", math_orig, 0);
        check("rst_final", math_final, 0);
        reset = 0;
        @(negedge clock);

        stray = 0;
        q1 = {12'h150}; q2 = {12'h260}; run_case("nominal");
        q1 = {12'h100, 12'h150}; q2 = {12'h260}; run_case("retry");
        q1 = {12'h055, 12'h0AA, 12'h001}; q2 = {}; run_case("exhaust");
        q1 = {12'h150}; q2 = {}; run_case("timeout2");
        stray = 1;
        q1 = {12'h231}; q2 = {12'h5FE}; run_case("stray");

        for (int i = 0; i < 30; i++) begin
            gen(q1);
            gen(q2);
            stray = $urandom_range(0, 1) == 1;
            run_case($sformatf("rnd%0d", i));
        end

        stray = 0;
        q1 = {12'h150};
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
        respond(q1, 1, lv);
        repeat (3) @(negedge clock);
        check("mid_move", move_forward, 1);
        reset = 1;
        @(negedge clock);
        reset = 0;
        exp_orig = '0; exp_final = '0; exp_orient = '0;
        check("mr_move", move_forward, 0);
        check("mr_busy", busy, 0);
        check("mr_req", loc_request, 0);
        check("mr_error", error, 0);
        check("mr_orig", math_orig, exp_orig);
        check("mr_final", math_final, exp_final);
        check("mr_orient", orientation, exp_orient);
        b_done = done_cnt;
        repeat (30) @(negedge clock);
        check("mr_no_done", done_cnt - b_done, 0);
        check("mr_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
